// File: rtl/bitmap_encoder_pkg.sv
// Shared definitions for the bitmap encoder slice.
//   ST_IDLE / ST_EMIT : registered FSM state encodings
//   code_width(n)     : binary code width needed to index an n-bit bitmap
package bitmap_encoder_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  function automatic int unsigned code_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitmap_encoder_lsb_prio_enc.sv
// Purely combinational lowest-set-bit priority encoder.
//   vec_i : input vector (N bits)
//   idx_o : index of lowest set bit, 0 when vec_i is zero (W bits)
//   any_o : at least one bit set
//   one_o : exactly one bit set
module lsb_prio_enc
  import bitmap_encoder_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = code_width(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         one_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i] && !found) begin
        idx_o = i[W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_o = |vec_i;
  // x & (x-1) clears the lowest set bit; zero afterwards means a single bit was set
  assign one_o = any_o && ((vec_i & (vec_i - ONE)) == '0);

endmodule

// File: rtl/bitmap_encoder.sv
// Sequential bitmap-to-index encoder: accepts an N-bit request bitmap and
// emits the index of each set bit, lowest first, one per output handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_bits = request bitmap
//   out_valid/out_ready : output handshake
//   out_code            : index of lowest pending set bit
//   out_last            : out_code is the final index of the current bitmap
//   zero_err            : one-cycle pulse after an all-zero bitmap is accepted
module bitmap_encoder
  import bitmap_encoder_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = code_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         zero_err
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic         state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_err_q, zero_err_d;

  logic [W-1:0] pend_idx;
  logic         pend_any;
  logic         pend_one;
  logic         in_fire;
  logic         out_fire;

  lsb_prio_enc #(.N(N)) u_pend_enc (
    .vec_i (pending_q),
    .idx_o (pend_idx),
    .any_o (pend_any),
    .one_o (pend_one)
  );

  assign out_valid = (state_q == ST_EMIT) && pend_any;
  assign out_code  = pend_idx;
  assign out_last  = pend_one;
  assign zero_err  = zero_err_q;

  // Ready is held low while reset is asserted so no transfer can be seen
  // by a source during reset; it rises as soon as rst_n deasserts.
  assign in_ready = rst_n &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_EMIT) && pend_one && out_ready));

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;

    if (out_fire) begin
      pending_d = pending_q & (pending_q - ONE);
      if (pend_one) begin
        state_d = ST_IDLE;
      end
    end

    // A new transfer in EMIT only happens on the final output beat, so it
    // overrides the (now empty) pending vector computed above.
    if (in_fire) begin
      if (|in_bits) begin
        pending_d = in_bits;
        state_d   = ST_EMIT;
      end else begin
        zero_err_d = 1'b1;
        state_d    = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule

// File: doc/bitmap_encoder.md
Name: bitmap_encoder

Overview:
- Sequential inverse of the team's 2-to-4 one-hot decoder.
- Accepts an N-bit request bitmap over a valid/ready handshake and emits the binary index of every set bit, lowest first, one index per output handshake.
- Flags an all-zero bitmap as an error.
- Sits between request sources, such as decoded select lines or interrupt bits, and any consumer that needs binary codes.

Parameters:
- N, 4, bitmap width; N >= 2 and a power of two (default pairs with the 2-to-4 decoder).
- W, $clog2(N), output code width; derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bits is valid.
- in_ready  output  1  block can accept a bitmap this cycle.
- in_bits  input  N  request bitmap.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code this cycle.
- out_code  output  W  index of lowest set bit still pending.
- out_last  output  1  current out_code is the final index of this bitmap.
- zero_err  output  1  one-cycle pulse: an all-zero bitmap was accepted.

Behaviour:
- Interface:
  - Clock is clk.
  - Reset rst_n is asynchronous, active-low.
  - All flops clear immediately on rst_n=0.
- Reset values:
  - state=IDLE, pending=0.
  - out_valid=0, out_code=0, out_last=0, zero_err=0.
  - in_ready=1 once rst_n deasserts.
- States: IDLE and EMIT (2-state FSM, registered state).
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==EMIT && out_last && out_ready).
  - This is a combinational ready path, allowing full throughput for one-hot inputs.
- IDLE:
  - On transfer with in_bits != 0: pending <= in_bits, go to EMIT.
  - On transfer with in_bits == 0: zero_err=1 for the next cycle only, stay IDLE, no output.
- EMIT, outputs:
  - out_valid=1.
  - out_code = index of lowest set bit of pending.
  - out_last = (pending has exactly one bit set).
  - Outputs are derived from the registered pending vector; no combinational path from in_bits.
- EMIT, output handshake (out_valid && out_ready):
  - Clear the lowest set bit of pending.
  - If out_last: go to IDLE, unless a new input transfer happens in the same cycle. In that case load the new bitmap (or pulse zero_err and go IDLE if it is zero).
- Stall: while out_valid && !out_ready, out_code, out_last and pending hold stable.
- Latency: out_valid rises 1 cycle after input transfer.
- Throughput:
  - A bitmap with k set bits occupies k output cycles.
  - One-hot inputs sustain 1 bitmap per cycle with out_ready held high.
- Boundaries:
  - in_bits all ones: emits 0,1,...,N-1 with out_last only on N-1.
  - Bit N-1 alone: out_code=N-1, out_last=1.
  - in_valid is ignored in EMIT when in_ready=0; the source must hold its data.
- Reset mid-EMIT: pending is discarded, out_valid drops asynchronously, no partial output resumes.
- zero_err never coincides with out_valid rising from the same transfer.

Decomposition:
- Shared package/include file: state encodings ST_IDLE=1'b0, ST_EMIT=1'b1.
- The W-from-N helper is derived in the same file.
- One natural sub-module, lsb_prio_enc (purely combinational, parameter N). It takes a vector and returns:
  - the lowest set index (W bits),
  - any-set,
  - exactly-one-set.
- The top level instantiates it once on pending, and once on in_bits for the zero check (or uses a reduction-OR).

Test Plan:
1. Reset: rst_n low mid-cycle -> all outputs 0 immediately. After release -> in_ready=1, out_valid=0.
2. One-hot stream, N=4, out_ready=1: in_bits 0001,0010,0100,1000 on consecutive cycles -> out_code 0,1,2,3 on consecutive cycles, each with out_last=1, in_ready never drops.
3. Multi-hot 1011 with out_ready=1 -> out_code 0,1,3 over 3 cycles; out_last only on 3; in_ready=0 during the first two.
4. Backpressure: bitmap 0110, out_ready=0 for 3 cycles -> out_code=1 held stable, out_last=0. Then out_ready=1 -> codes 1 then 2 (last).
5. Zero input: in_bits 0000 accepted -> zero_err=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
6. Reset mid-EMIT: bitmap 1111, assert rst_n after the second code -> out_valid=0 at once. After release, a new 0100 -> single code 2 with out_last=1.
